// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with a tagged valid/ready result port.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             stall_req
);

    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q;
    logic             neg_r;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [XLEN-1:0]  mplier_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;

    // Request decode: operand signedness, magnitudes and the two divide corner cases
    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            accept;
    logic            last_step;

    assign a_sgn = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_sgn = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_mag = (a_sgn && a[XLEN-1]) ? -a : a;
    assign b_mag = (b_sgn && b[XLEN-1]) ? -b : b;

    assign div_zero    = (b == '0);
    assign div_ovf     = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    assign special     = op[2] && (div_zero || div_ovf);
    assign special_res = op[1] ? (div_zero ? a : '0) : (div_zero ? '1 : a);

    assign accept    = (state == IDLE) && in_valid && !flush;
    assign last_step = (cnt_q == CNT_W'(XLEN - 1));

    // One iteration of each algorithm; the final iteration's values feed the result directly
    logic [PW-1:0]   acc_n;
    logic [XLEN:0]   rem_shift, rem_diff;
    logic [XLEN-1:0] rem_n, quo_n;
    logic [PW-1:0]   prod_f;
    logic [XLEN-1:0] quo_f, rem_f, final_res;

    always_comb begin
        acc_n     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_shift = {rem_q, quo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        if (!rem_diff[XLEN]) begin
            rem_n = rem_diff[XLEN-1:0];
            quo_n = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_n = rem_shift[XLEN-1:0];
            quo_n = {quo_q[XLEN-2:0], 1'b0};
        end
        prod_f = neg_q ? -acc_n : acc_n;
        quo_f  = neg_q ? -quo_n : quo_n;
        rem_f  = neg_r ? -rem_n : rem_n;
        case (op_q)
            OP_MUL:                      final_res = prod_f[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_f[PW-1:XLEN];
            OP_DIV, OP_DIVU:             final_res = quo_f;
            OP_REM, OP_REMU:             final_res = rem_f;
            default:                     final_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        stall_req = 1'b0;
        case (state)
            IDLE: begin
                in_ready  = 1'b1;
                stall_req = in_valid && !flush;
                if (accept) state_n = special ? DONE : CALC;
            end
            CALC: begin
                stall_req = 1'b1;
                if (flush)          state_n = IDLE;
                else if (last_step) state_n = DONE;
            end
            DONE: begin
                stall_req = 1'b1;
                out_valid = 1'b1;
                if (flush || out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result   <= '0;
            tag_out  <= '0;
        end else if (accept) begin
            op_q     <= op;
            tag_q    <= tag_in;
            cnt_q    <= '0;
            neg_q    <= (a_sgn & a[XLEN-1]) ^ (b_sgn & b[XLEN-1]);
            neg_r    <= a_sgn & a[XLEN-1];
            mcand_q  <= PW'(a_mag);
            acc_q    <= '0;
            mplier_q <= b_mag;
            dvs_q    <= b_mag;
            quo_q    <= a_mag;
            rem_q    <= '0;
            if (special) begin
                result  <= special_res;
                tag_out <= tag_in;
            end
        end else if (state == CALC && !flush) begin
            cnt_q    <= cnt_q + CNT_W'(1);
            acc_q    <= acc_n;
            mcand_q  <= {mcand_q[PW-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
            quo_q    <= quo_n;
            rem_q    <= rem_n;
            if (last_step) begin
                result  <= final_res;
                tag_out <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .tag_in(tag_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .tag_out(tag_out), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, return edges from accept until out_valid (100 = timed out)
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t, output int lat);
        in_valid = 1'b1; op = o; a = x; b = y; tag_in = t;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if (tag_out !== 5'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", tag_out); end
    endtask

    task automatic test_mul();
        int lat;
        in_valid = 1'b1; op = 3'b000; a = 32'd7; b = 32'hFFFF_FFFD; tag_in = 5'd3;
        #1;
        total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL idle_req_stall got=%b exp=1", stall_req); end
        in_valid = 1'b0;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, lat);
        total++; if (lat != 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        total++; if (result !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_result got=%h exp=ffffffeb", result); end
        total++; if (tag_out !== 5'd3) begin bad++; $display("FAIL mul_tag got=%0d exp=3", tag_out); end
        pop();
    endtask

    task automatic test_mulh();
        int lat;
        logic [2:0]  ops [4] = '{3'b001, 3'b011, 3'b010, 3'b001};
        logic [31:0] as  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        logic [31:0] bs  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd5};
        logic [31:0] exps[4] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 4), lat);
            total++; if (lat != 33) begin bad++; $display("FAIL mulh_latency[%0d] got=%0d exp=33", i, lat); end
            total++; if (result !== exps[i]) begin bad++; $display("FAIL mulh_result[%0d] got=%h exp=%h", i, result, exps[i]); end
            pop();
        end
    endtask

    task automatic test_div();
        int lat;
        logic [2:0]  ops [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] exps[6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 10), lat);
            total++; if (lat != 33) begin bad++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, lat); end
            total++; if (result !== exps[i]) begin bad++; $display("FAIL div_result[%0d] got=%h exp=%h", i, result, exps[i]); end
            total++; if (tag_out !== 5'(i + 10)) begin bad++; $display("FAIL div_tag[%0d] got=%0d exp=%0d", i, tag_out, i + 10); end
            pop();
        end
    endtask

    task automatic test_special();
        int lat;
        logic [2:0]  ops [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] as  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exps[6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 20), lat);
            total++; if (lat != 1) begin bad++; $display("FAIL special_latency[%0d] got=%0d exp=1", i, lat); end
            total++; if (result !== exps[i]) begin bad++; $display("FAIL special_result[%0d] got=%h exp=%h", i, result, exps[i]); end
            total++; if (tag_out !== 5'(i + 20)) begin bad++; $display("FAIL special_tag[%0d] got=%0d exp=%0d", i, tag_out, i + 20); end
            pop();
        end
    endtask

    task automatic test_flush();
        int lat;
        int seen = 0;
        in_valid = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9; tag_in = 5'd1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_calc_idle got=%b exp=1", in_ready); end
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_no_valid got=%0d exp=0", seen); end
        issue(3'b000, 32'd3, 32'd4, 5'd2, lat);
        total++; if (lat != 33) begin bad++; $display("FAIL flush_mul_latency got=%0d exp=33", lat); end
        total++; if (result !== 32'd12) begin bad++; $display("FAIL flush_mul_result got=%h exp=c", result); end
        pop();
        // Flush in IDLE blocks accept and the stall request
        in_valid = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd1; b = 32'd1;
        #1;
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b exp=0", stall_req); end
        tick();
        in_valid = 1'b0; flush = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_idle_accept got=%b exp=1", in_ready); end
        // Flush in DONE beats out_ready
        issue(3'b101, 32'd1, 32'd0, 5'd5, lat);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_done got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(3'b101, 32'd100, 32'd7, 5'd9, lat);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || result !== 32'd14 || tag_out !== 5'd9 || stall_req !== 1'b1) begin
                bad++;
                $display("FAIL hold[%0d] got v=%b r=%h t=%0d s=%b exp v=1 r=e t=9 s=1", i, out_valid, result, tag_out, stall_req);
            end
            tick();
        end
        in_valid = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2; tag_in = 5'd4;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL no_accept_on_pop got=%b/%b exp=1/0", in_ready, out_valid); end
        issue(3'b000, 32'd2, 32'd2, 5'd4, lat);
        total++; if (result !== 32'd4 || lat != 33) begin bad++; $display("FAIL next_op got=%h lat=%0d exp=4 lat=33", result, lat); end
        pop();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; op = 3'b100; a = 32'd50; b = 32'd3; tag_in = 5'd7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_mid_ready got=%b exp=1", in_ready); end
        total++; if (result !== 32'h0 || tag_out !== 5'd0) begin bad++; $display("FAIL reset_mid_result got=%h/%0d exp=0/0", result, tag_out); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; tag_in = '0;
        flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width; legal values 8 to 64, even.
REQ-002 SHALL have parameter TAG_W, default 5: width of the destination-register tag carried with each operation.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operation request.
REQ-006 SHALL have port in_ready, output, 1: unit accepts a request this cycle.
REQ-007 SHALL have port op, input, 3: RV32M funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port a, input, XLEN: operand rs1.
REQ-009 SHALL have port b, input, XLEN: operand rs2.
REQ-010 SHALL have port tag_in, input, TAG_W: rd of the request.
REQ-011 SHALL have port flush, input, 1: kill the in-flight operation.
REQ-012 SHALL have port out_valid, output, 1: result available.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-014 SHALL have port result, output, XLEN: operation result.
REQ-015 SHALL have port tag_out, output, TAG_W: tag of the result.
REQ-016 SHALL have port stall_req, output, 1: pipeline stall request to the hazard logic.

Function
REQ-017 SHALL implement FSM states IDLE, CALC and DONE.
REQ-018 SHALL drive in_ready=1 only in IDLE.
REQ-019 SHALL drive stall_req=1 in CALC and DONE.
REQ-020 SHALL drive stall_req=1 in IDLE when in_valid=1 and flush=0.
REQ-021 SHALL accept a request on an edge where in_valid&in_ready&~flush, latching op, a, b and tag_in.
REQ-022 SHALL transition IDLE->CALC on accept for normal operations.
REQ-023 SHALL transition IDLE->DONE directly for special divide cases: b==0, or signed DIV/REM with a==most-negative and b==all-ones.
REQ-024 SHALL compute multiplies by radix-2 shift-add on a 2*XLEN product, using magnitudes with sign fix-up for signed forms: MULH both signed, MULHSU a signed and b unsigned.
REQ-025 SHALL compute divides by restoring division on magnitudes, one quotient bit per cycle.
REQ-026 SHALL give the quotient the sign of a^b for signed forms.
REQ-027 SHALL give the remainder the sign of a for signed forms.
REQ-028 SHALL stay in CALC exactly XLEN cycles, then move to DONE.
REQ-029 SHALL assert out_valid first on the (XLEN+1)th edge after accept for normal operations.
REQ-030 SHALL assert out_valid on the 1st edge after accept for special divide cases.
REQ-031 SHALL return, for MUL, product[XLEN-1:0].
REQ-032 SHALL return, for MULH, MULHSU and MULHU, product[2*XLEN-1:XLEN].
REQ-033 SHALL return, on divide by zero, quotient all-ones and remainder a for both signed and unsigned forms.
REQ-034 SHALL return, on signed overflow, quotient a and remainder 0.
REQ-035 SHALL drive out_valid=1 only in DONE.
REQ-036 SHALL hold result and tag_out stable while out_valid=1 and out_ready=0.
REQ-037 SHALL transition DONE->IDLE on an edge with out_ready=1.
REQ-038 SHALL NOT accept a new request in the same cycle as a DONE->IDLE transition, since in_ready=0 in DONE.
REQ-039 SHALL, on flush=1, go to IDLE on the next edge from any state, with no out_valid for the killed operation.
REQ-040 SHALL give flush priority over a simultaneous accept and over DONE->IDLE.
REQ-041 SHALL hold result and tag_out when out_valid=0; their values are then don't-care to consumers.

Reset
REQ-042 SHALL, on reset=1 at a rising edge, enter IDLE, abandoning any operation mid-flight.
REQ-043 SHALL, after reset, drive out_valid=0, in_ready=1, stall_req=0 (while in_valid=0), result=0 and tag_out=0.
REQ-044 SHALL give reset priority over flush and over all handshakes.

Verification
REQ-045 SHALL cover, with XLEN=32: MUL a=7, b=0xFFFFFFFD, tag 3 -> out_valid on the 33rd edge, result 0xFFFFFFEB, tag_out 3.
REQ-046 SHALL cover: MULH a=b=0x80000000 -> result 0x40000000; MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE.
REQ-047 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14.
REQ-048 SHALL cover: DIVU a=5, b=0 -> 0xFFFFFFFF after 1 edge; REMU -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-049 SHALL cover: flush asserted on CALC cycle 10 -> IDLE next edge, no out_valid. Then a new MUL 3*4 -> 12.
REQ-050 SHALL cover: out_ready held low 5 cycles in DONE -> result/tag_out stable, stall_req=1; reset asserted mid-CALC -> out_valid=0, in_ready=1 next cycle.
